vga_text_render: RTL

//  Pixel stage downstream of the VGA timing generator (720x400 @ 70 Hz text timing).

---
 rtl/vga_text_render_if.sv | 18 +
 rtl/vga_text_render.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_render_if.sv
// ---------------------------------------------------------------------------
// vga_text_render_if
// Purpose : character/attribute RAM write bus for vga_text_render.
//           The host (CPU side) drives the bus through the master modport;
//           the renderer receives it through the slave modport.
// Signals :
//   wr_en    1   write strobe, sampled on the pixel clock
//   wr_addr  11  cell index = row*80+col (indices >= 2000 are dropped)
//   wr_data  16  [7:0] code, [11:8] fg, [14:12] bg, [15] blink
// ---------------------------------------------------------------------------
interface vga_text_render_if;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/vga_text_render.sv
// ---------------------------------------------------------------------------
// vga_text_render
// Purpose : pixel stage behind a 720x400 @ 70 Hz VGA timing generator.
//           Renders an 80x25 text screen of 9x16 cells from an internal
//           2000-entry character/attribute RAM, an external font ROM and the
//           16-colour CGA palette. Output is 4 clocks behind the input counts;
//           hsync/vsync are delayed by the same amount.
// Ports   :
//   clk        in   pixel clock
//   rst        in   synchronous reset, active-low
//   h_cnt      in   11  horizontal count (visible < 720, must step by 1 from 0)
//   v_cnt      in   10  vertical count (visible < 400)
//   hsync      in   horizontal sync from timing generator
//   vsync      in   vertical sync from timing generator
//   wr         slave modport of vga_text_render_if (char RAM write bus)
//   font_addr  out  12  {code, line} to the font ROM
//   font_data  in   8   glyph row, one clock after font_addr, bit 7 leftmost
//   rgb        out  12  {R,G,B} 4 bits each
//   hsync_o    out  hsync delayed 4 clocks
//   vsync_o    out  vsync delayed 4 clocks
// Configuration:
//   VGA_TEXT_CURSOR_EN  adds cursor_col[6:0], cursor_row[4:0], cursor_on and
//                       an underline cursor on lines 14-15 of the selected
//                       cell, blinking with frame_cnt[3].
// ---------------------------------------------------------------------------
module vga_text_render (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        hsync,
    input  logic        vsync,
    vga_text_render_if.slave wr,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o
`ifdef VGA_TEXT_CURSOR_EN
    ,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_on
`endif
);

    localparam int COLS     = 80;
    localparam int ROWS     = 25;
    localparam int CELLS    = COLS * ROWS;
    localparam int CELL_W   = 9;
    localparam int PIPE_LAT = 4;

    localparam logic [3:0]  LAST_PX   = 4'(CELL_W - 1);
    localparam logic [11:0] CELLS_12  = 12'(CELLS);
    localparam logic [10:0] CELLS_11  = 11'(CELLS);

    function automatic logic [11:0] cga_pal(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'h0:    c = 12'h000;
            4'h1:    c = 12'h00A;
            4'h2:    c = 12'h0A0;
            4'h3:    c = 12'h0AA;
            4'h4:    c = 12'hA00;
            4'h5:    c = 12'hA0A;
            4'h6:    c = 12'hA50;
            4'h7:    c = 12'hAAA;
            4'h8:    c = 12'h555;
            4'h9:    c = 12'h55F;
            4'hA:    c = 12'h5F5;
            4'hB:    c = 12'h5FF;
            4'hC:    c = 12'hF55;
            4'hD:    c = 12'hF5F;
            4'hE:    c = 12'hFF5;
            default: c = 12'hFFF;
        endcase
        return c;
    endfunction

    // ---------------- C0: cell position counters ----------------
    logic [3:0] px_c0, px_n;
    logic [6:0] col_c0, col_n;
    logic [5:0] row_c0;
    logic [3:0] line_c0;
    logic       vis_c0;

    // Counters track h_cnt%9 and h_cnt/9 incrementally so no divider is needed.
    always_comb begin
        px_n  = px_c0 + 4'd1;
        col_n = col_c0;
        if (h_cnt == 11'd0) begin
            px_n  = 4'd0;
            col_n = 7'd0;
        end else if (px_c0 == LAST_PX) begin
            px_n  = 4'd0;
            col_n = col_c0 + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            px_c0   <= 4'd0;
            col_c0  <= 7'd0;
            row_c0  <= 6'd0;
            line_c0 <= 4'd0;
            vis_c0  <= 1'b0;
        end else begin
            px_c0   <= px_n;
            col_c0  <= col_n;
            row_c0  <= v_cnt[9:4];
            line_c0 <= v_cnt[3:0];
            vis_c0  <= (h_cnt < 11'd720) && (v_cnt < 10'd400);
        end
    end

    // ---------------- C1: character RAM ----------------
    logic [15:0] ram [0:CELLS-1];
    logic [15:0] ram_q;
    logic [11:0] addr_full;
    logic [10:0] rd_idx;

    // row*80 = row*64 + row*16. Off-screen positions read cell 0 so the
    // index never leaves the array; their output is blanked anyway.
    assign addr_full = {row_c0, 6'b0} + {2'b0, row_c0, 4'b0} + {5'b0, col_c0};
    assign rd_idx    = (vis_c0 && (addr_full < CELLS_12)) ? addr_full[10:0] : 11'd0;

    // Read-first: a write to the address being read returns the old word.
    always_ff @(posedge clk) begin
        if (wr.wr_en && (wr.wr_addr < CELLS_11)) begin
            ram[wr.wr_addr] <= wr.wr_data;
        end
        ram_q <= ram[rd_idx];
    end

    logic [3:0] px_c1, line_c1;
    logic       vis_c1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            px_c1   <= 4'd0;
            line_c1 <= 4'd0;
            vis_c1  <= 1'b0;
        end else begin
            px_c1   <= px_c0;
            line_c1 <= line_c0;
            vis_c1  <= vis_c0;
        end
    end

    // ---------------- C2: font ROM lookup ----------------
    assign font_addr = {ram_q[7:0], line_c1};

    logic [7:0] attr_c2;
    logic [3:0] px_c2;
    logic       vis_c2;
    logic       box_c2;

    // Box-drawing codes 0xC0..0xDF extend their rightmost glyph pixel into
    // the gap column so horizontal lines stay unbroken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            attr_c2 <= 8'd0;
            px_c2   <= 4'd0;
            vis_c2  <= 1'b0;
            box_c2  <= 1'b0;
        end else begin
            attr_c2 <= ram_q[15:8];
            px_c2   <= px_c1;
            vis_c2  <= vis_c1;
            box_c2  <= (ram_q[7:5] == 3'b110);
        end
    end

    // ---------------- frame counter ----------------
    logic       vsync_d;
    logic [4:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_d   <= 1'b1;
            frame_cnt <= 5'd0;
        end else begin
            vsync_d <= vsync;
            if (vsync_d && !vsync) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
        end
    end

    // ---------------- cursor ----------------
    logic cur_force;

`ifdef VGA_TEXT_CURSOR_EN
    logic cur_c0, cur_c1, cur_c2;

    // Compared against the next-cycle column so it lines up with px_c0/col_c0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_c0 <= 1'b0;
            cur_c1 <= 1'b0;
            cur_c2 <= 1'b0;
        end else begin
            cur_c0 <= cursor_on && (col_n == cursor_col) &&
                      (v_cnt[9:4] == {1'b0, cursor_row}) && (v_cnt[3:1] == 3'b111);
            cur_c1 <= cur_c0;
            cur_c2 <= cur_c1;
        end
    end

    assign cur_force = cur_c2 && frame_cnt[3];
`else
    assign cur_force = 1'b0;
`endif

    // ---------------- C3: pixel select and palette ----------------
    logic glyph_bit;
    logic pix_on;

    // For px 0..7, ~px[2:0] equals 7-px, selecting bit 7 for the leftmost pixel.
    always_comb begin
        glyph_bit = 1'b0;
        if (px_c2[3] == 1'b0) begin
            glyph_bit = font_data[~px_c2[2:0]];
        end else if (box_c2) begin
            glyph_bit = font_data[0];
        end
        pix_on = cur_force | (glyph_bit & ~(attr_c2[7] & frame_cnt[4]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb <= 12'h000;
        end else if (!vis_c2) begin
            rgb <= 12'h000;
        end else if (pix_on) begin
            rgb <= cga_pal(attr_c2[3:0]);
        end else begin
            rgb <= cga_pal({1'b0, attr_c2[6:4]});
        end
    end

    // ---------------- sync delay ----------------
    logic [PIPE_LAT-1:0] hs_sr, vs_sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_sr <= '1;
            vs_sr <= '1;
        end else begin
            hs_sr <= {hs_sr[PIPE_LAT-2:0], hsync};
            vs_sr <= {vs_sr[PIPE_LAT-2:0], vsync};
        end
    end

    assign hsync_o = hs_sr[PIPE_LAT-1];
    assign vsync_o = vs_sr[PIPE_LAT-1];

endmodule
